// File: rtl/icache.sv
// ============================================================================
// Module   : icache
// Purpose  : Direct-mapped instruction cache for the fetch stage. It accepts
//            one fetch per cycle and answers a hit one cycle later. A miss
//            refills the whole line, one word per memory beat, and then
//            answers from the filled line. A pipeline flush kills the
//            in-flight answer, and fence.i invalidates every line.
// Ports    : clk, rst                  - clock, synchronous active-high reset
//            if_req_i, if_pc_i         - fetch request and address
//            fc_flush_icache_i         - kill the previously accepted request
//            fc_inv_icache_i           - invalidate all lines (fence.i)
//            Icache_ready_o/inst_o     - response pulse and instruction word
//            Icache_busy_o             - new requests ignored this cycle
//            icache_mem_req_o/addr_o   - refill beat request and word address
//            mem_icache_valid_i/data_i - refill beat completion and data
// Options  : ICACHE_PERF_EN adds icache_hit_cnt_o / icache_miss_cnt_o
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module icache #(
    parameter int LINE_WORDS = 4,
    parameter int NUM_LINES  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_pc_i,
    input  logic        fc_flush_icache_i,
    input  logic        fc_inv_icache_i,
    output logic        Icache_ready_o,
    output logic [31:0] Icache_inst_o,
    output logic        Icache_busy_o,
    output logic        icache_mem_req_o,
    output logic [31:0] icache_mem_addr_o,
    input  logic        mem_icache_valid_i,
    input  logic [31:0] mem_icache_data_i
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0] icache_hit_cnt_o,
    output logic [31:0] icache_miss_cnt_o
`endif
);

    localparam int c_BEAT_W = $clog2(LINE_WORDS);
    localparam int c_OFF_W  = c_BEAT_W + 2;
    localparam int c_IDX_W  = $clog2(NUM_LINES);
    localparam int c_TAG_W  = 32 - c_OFF_W - c_IDX_W;

    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(LINE_WORDS - 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_REFILL = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    // Control state
    logic [1:0]          r_state;
    logic [31:2]         r_req_pc;
    logic                r_pend;
    logic                r_drop;
    logic                r_inv_pend;
    logic [c_BEAT_W-1:0] r_beat;
    logic [31:0]         r_inst;
    logic [NUM_LINES-1:0] r_valid;

    // Storage arrays (not reset; the valid bits qualify them)
    logic [c_TAG_W-1:0]  r_tag  [NUM_LINES];
    logic [31:0]         r_data [NUM_LINES*LINE_WORDS];

    logic [c_IDX_W-1:0]  w_idx;
    logic [c_BEAT_W-1:0] w_off;
    logic [c_TAG_W-1:0]  w_tag;
    logic [31:0]         w_rd_data;
    logic                w_lookup;
    logic                w_hit;
    logic                w_miss;
    logic                w_ready;
    logic                w_busy;
    logic                w_accept;
    logic                w_beat_done;
    logic                w_last_beat;
    logic                w_unused;

    // Byte-offset bits never affect a word fetch.
    assign w_unused = ^if_pc_i[1:0];

    assign w_idx     = r_req_pc[c_OFF_W+c_IDX_W-1:c_OFF_W];
    assign w_off     = r_req_pc[c_OFF_W-1:2];
    assign w_tag     = r_req_pc[31:c_OFF_W+c_IDX_W];
    assign w_rd_data = r_data[{w_idx, w_off}];

    // The lookup reads the valid bits as they were before any same-cycle
    // invalidate, because the clear only lands at the clock edge.
    assign w_lookup = r_pend && (r_state == c_IDLE);
    assign w_hit    = w_lookup && r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_miss   = w_lookup && !w_hit;

    // A flush seen in RESP suppresses the pulse just as a registered drop does.
    assign w_ready = (w_hit && !fc_flush_icache_i) ||
                     ((r_state == c_RESP) && !r_drop && !fc_flush_icache_i);

    // A flushed miss starts no refill, so it does not block the redirect.
    assign w_busy   = (r_state != c_IDLE) || (w_miss && !fc_flush_icache_i);
    assign w_accept = if_req_i && !w_busy;

    assign w_beat_done = (r_state == c_REFILL) && mem_icache_valid_i;
    assign w_last_beat = (r_beat == c_LAST_BEAT);

    assign Icache_ready_o    = w_ready;
    assign Icache_inst_o     = w_ready ? w_rd_data : r_inst;
    assign Icache_busy_o     = w_busy;
    assign icache_mem_req_o  = (r_state == c_REFILL);
    assign icache_mem_addr_o = (r_state == c_REFILL) ?
                               {r_req_pc[31:c_OFF_W], r_beat, 2'b00} : 32'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_req_pc   <= '0;
            r_pend     <= 1'b0;
            r_drop     <= 1'b0;
            r_inv_pend <= 1'b0;
            r_beat     <= '0;
            r_inst     <= 32'd0;
            r_valid    <= '0;
        end else begin
            if (w_ready) begin
                r_inst <= w_rd_data;
            end

            case (r_state)
                c_IDLE: begin
                    if (w_lookup) begin
                        if (w_miss && !fc_flush_icache_i) begin
                            r_state <= c_REFILL;
                            r_beat  <= '0;
                        end else begin
                            r_pend <= 1'b0;
                        end
                    end
                    if (fc_inv_icache_i) begin
                        r_valid <= '0;
                    end
                end

                c_REFILL: begin
                    if (fc_flush_icache_i) begin
                        r_drop <= 1'b1;
                    end
                    if (fc_inv_icache_i) begin
                        r_inv_pend <= 1'b1;
                    end
                    if (mem_icache_valid_i) begin
                        r_beat <= r_beat + c_BEAT_W'(1);
                        if (w_last_beat) begin
                            r_valid[w_idx] <= 1'b1;
                            r_state        <= c_RESP;
                        end
                    end
                end

                c_RESP: begin
                    r_state    <= c_IDLE;
                    r_pend     <= 1'b0;
                    r_drop     <= 1'b0;
                    r_inv_pend <= 1'b0;
                    // Deferred fence.i also wipes the line just filled.
                    if (r_inv_pend || fc_inv_icache_i) begin
                        r_valid <= '0;
                    end
                end

                default: begin
                    r_state <= c_IDLE;
                end
            endcase

            // Placed last so a same-cycle accept wins over the pend clear.
            if (w_accept) begin
                r_req_pc <= if_pc_i[31:2];
                r_pend   <= 1'b1;
            end
        end
    end

    // Line storage: written only by refill beats, so it can map to RAM.
    always_ff @(posedge clk) begin
        if (w_beat_done && !rst) begin
            r_data[{w_idx, r_beat}] <= mem_icache_data_i;
            if (w_last_beat) begin
                r_tag[w_idx] <= w_tag;
            end
        end
    end

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= 32'd0;
            r_miss_cnt <= 32'd0;
        end else if (!fc_flush_icache_i) begin
            if (w_hit) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_miss) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign icache_hit_cnt_o  = r_hit_cnt;
    assign icache_miss_cnt_o = r_miss_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_icache.sv
// ============================================================================
// Module   : tb_icache
// Purpose  : Directed self-checking bench for icache. A behavioural memory
//            returns word 0xA0 + (addr - 0x100)/4 for every refill beat, with
//            a programmable number of wait cycles before each beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_icache;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_pc_i;
    logic        fc_flush_icache_i;
    logic        fc_inv_icache_i;
    logic        Icache_ready_o;
    logic [31:0] Icache_inst_o;
    logic        Icache_busy_o;
    logic        icache_mem_req_o;
    logic [31:0] icache_mem_addr_o;
    logic        mem_icache_valid_i;
    logic [31:0] mem_icache_data_i;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    int          mem_wait = 0;
    int          wcnt     = 0;
    logic [31:0] beat_log [$];
    logic [31:0] req_log  [$];

    icache #(.LINE_WORDS(4), .NUM_LINES(64)) dut (
        .clk                (clk),
        .rst                (rst),
        .if_req_i           (if_req_i),
        .if_pc_i            (if_pc_i),
        .fc_flush_icache_i  (fc_flush_icache_i),
        .fc_inv_icache_i    (fc_inv_icache_i),
        .Icache_ready_o     (Icache_ready_o),
        .Icache_inst_o      (Icache_inst_o),
        .Icache_busy_o      (Icache_busy_o),
        .icache_mem_req_o   (icache_mem_req_o),
        .icache_mem_addr_o  (icache_mem_addr_o),
`ifdef ICACHE_PERF_EN
        .icache_hit_cnt_o   (hit_cnt),
        .icache_miss_cnt_o  (miss_cnt),
`endif
        .mem_icache_valid_i (mem_icache_valid_i),
        .mem_icache_data_i  (mem_icache_data_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hA0 + ((a - 32'h100) >> 2);
    endfunction

    // Memory model: decides at the falling edge whether the beat completes
    // at the next rising edge.
    initial begin
        mem_icache_valid_i = 1'b0;
        mem_icache_data_i  = 32'd0;
        forever begin
            @(negedge clk);
            if (icache_mem_req_o && !rst) begin
                req_log.push_back(icache_mem_addr_o);
                if (wcnt >= mem_wait) begin
                    mem_icache_valid_i = 1'b1;
                    mem_icache_data_i  = mem_word(icache_mem_addr_o);
                    beat_log.push_back(icache_mem_addr_o);
                    wcnt = 0;
                end else begin
                    mem_icache_valid_i = 1'b0;
                    wcnt++;
                end
            end else begin
                mem_icache_valid_i = 1'b0;
                wcnt = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for one cycle; returns in the lookup cycle.
    task automatic req(input logic [31:0] pc);
        if_req_i = 1'b1;
        if_pc_i  = pc;
        tick();
        if_req_i = 1'b0;
    endtask

    task automatic wait_ready(input int max, output int cyc, output logic got);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < max) begin
            tick();
            cyc++;
            if (Icache_ready_o) got = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        int   n;
        int   pulses;
        logic got;

        rst = 1'b1;
        if_req_i = 1'b0;
        if_pc_i = 32'd0;
        fc_flush_icache_i = 1'b0;
        fc_inv_icache_i = 1'b0;
        tick();
        tick();
        check("rst_ready", Icache_ready_o, 0);
        check("rst_inst", Icache_inst_o, 0);
        check("rst_busy", Icache_busy_o, 0);
        check("rst_memreq", icache_mem_req_o, 0);
        check("rst_memaddr", icache_mem_addr_o, 0);
        rst = 1'b0;
        tick();

        // Cold miss on 0x104, zero-wait memory
        beat_log.delete();
        req(32'h104);
        check("s1_lookup_busy", Icache_busy_o, 1);
        check("s1_lookup_ready", Icache_ready_o, 0);
        wait_ready(40, cyc, got);
        check("s1_got_ready", got, 1);
        check("s1_latency", cyc, 5);
        check("s1_inst", Icache_inst_o, 32'hA1);
        check("s1_resp_busy", Icache_busy_o, 1);
        check("s1_beats", beat_log.size(), 4);
        for (int i = 0; i < 4 && i < beat_log.size(); i++)
            check("s1_beat_addr", beat_log[i], 32'h100 + 32'(4 * i));
        tick();
        check("s1_idle_busy", Icache_busy_o, 0);
        check("s1_idle_ready", Icache_ready_o, 0);
        check("s1_inst_hold", Icache_inst_o, 32'hA1);

        // Back-to-back hits, one per cycle
        if_req_i = 1'b1;
        if_pc_i  = 32'h100;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i < 3) if_pc_i = 32'h104 + 32'(4 * i);
            else if_req_i = 1'b0;
            check("s2_ready", Icache_ready_o, 1);
            check("s2_inst", Icache_inst_o, 32'hA0 + 32'(i));
            check("s2_busy", Icache_busy_o, 0);
            check("s2_memreq", icache_mem_req_o, 0);
        end
        tick();
        check("s2_after_ready", Icache_ready_o, 0);
        check("s2_inst_hold", Icache_inst_o, 32'hA3);
`ifdef ICACHE_PERF_EN
        check("perf_hit", hit_cnt, 4);
        check("perf_miss", miss_cnt, 1);
`endif

        // Miss with 3 wait cycles per beat on 0x148
        mem_wait = 3;
        beat_log.delete();
        req_log.delete();
        req(32'h148);
        check("s3_lookup_busy", Icache_busy_o, 1);
        wait_ready(60, cyc, got);
        check("s3_got_ready", got, 1);
        check("s3_inst", Icache_inst_o, 32'hB2);
        check("s3_beats", beat_log.size(), 4);
        check("s3_req_cycles", req_log.size(), 16);
        for (int i = 0; i < 16 && i < req_log.size(); i++)
            check("s3_addr_hold", req_log[i], 32'h140 + 32'(4 * (i / 4)));
        tick();

        // Flush during refill of 0x200, then redirect to 0x104
        req(32'h200);
        check("s4_lookup_busy", Icache_busy_o, 1);
        tick();
        tick();
        fc_flush_icache_i = 1'b1;
        tick();
        fc_flush_icache_i = 1'b0;
        pulses = 0;
        n = 0;
        while (Icache_busy_o && n < 60) begin
            if (Icache_ready_o) pulses++;
            tick();
            n++;
        end
        check("s4_no_pulse", pulses, 0);
        check("s4_busy_drop", Icache_busy_o, 0);
        mem_wait = 0;
        req(32'h104);
        check("s4_redirect_ready", Icache_ready_o, 1);
        check("s4_redirect_inst", Icache_inst_o, 32'hA1);
        req(32'h200);
        check("s4_line_ready", Icache_ready_o, 1);
        check("s4_line_inst", Icache_inst_o, 32'hE0);
        check("s4_line_busy", Icache_busy_o, 0);

        // Invalidate in IDLE, then 0x104 misses
        fc_inv_icache_i = 1'b1;
        tick();
        fc_inv_icache_i = 1'b0;
        req(32'h104);
        check("s5_inv_busy", Icache_busy_o, 1);
        check("s5_inv_ready", Icache_ready_o, 0);
        tick();
        check("s5_memreq", icache_mem_req_o, 1);
        check("s5_memaddr", icache_mem_addr_o, 32'h100);
        wait_ready(40, cyc, got);
        check("s5_got_ready", got, 1);
        check("s5_inst", Icache_inst_o, 32'hA1);
        tick();

        // Invalidate during refill of 0x300
        req(32'h300);
        tick();
        fc_inv_icache_i = 1'b1;
        tick();
        fc_inv_icache_i = 1'b0;
        wait_ready(40, cyc, got);
        check("s5b_got_ready", got, 1);
        check("s5b_inst", Icache_inst_o, 32'h120);
        tick();
        req(32'h300);
        check("s5b_remiss_busy", Icache_busy_o, 1);
        check("s5b_remiss_ready", Icache_ready_o, 0);
        wait_ready(40, cyc, got);
        check("s5b_refill_inst", Icache_inst_o, 32'h120);
        tick();

        // Reset at beat 2 of a refill of 0x180
        req(32'h180);
        n = 0;
        while (!(icache_mem_req_o && icache_mem_addr_o == 32'h188) && n < 20) begin
            tick();
            n++;
        end
        check("s6_reach_beat2", icache_mem_addr_o, 32'h188);
        rst = 1'b1;
        tick();
        check("s6_ready", Icache_ready_o, 0);
        check("s6_inst", Icache_inst_o, 0);
        check("s6_busy", Icache_busy_o, 0);
        check("s6_memreq", icache_mem_req_o, 0);
        check("s6_memaddr", icache_mem_addr_o, 0);
        rst = 1'b0;
        tick();
        req(32'h180);
        check("s6_remiss_busy", Icache_busy_o, 1);
        tick();
        check("s6_beat0_addr", icache_mem_addr_o, 32'h180);
        wait_ready(40, cyc, got);
        check("s6_got_ready", got, 1);
        check("s6_refill_inst", Icache_inst_o, 32'hC0);
        tick();
        req(32'h104);
        check("s6_old_line_miss", Icache_busy_o, 1);
        wait_ready(40, cyc, got);
        check("s6_old_line_inst", Icache_inst_o, 32'hA1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
